// File: rtl/stg5wb_pkg.sv
// Shared widths, opcodes and target-field layout for the write-back stage.
// Optional write-through bypass is enabled by defining STG5WB_BYPASS_EN.
package stg5wb_pkg;

   localparam int unsigned SIZE_ADDR   = 24;
   localparam int unsigned SIZE_DATA   = 24;
   localparam int unsigned SIZE_OPC    = 8;
   localparam int unsigned SIZE_TGT_GP = 5;
   localparam int unsigned SIZE_TGT_SR = 3;

   localparam int unsigned NUM_GP = 16;
   localparam int unsigned NUM_SR = 4;

   localparam logic [SIZE_OPC-1:0] OPC_NOP = 8'h00;
   localparam logic [SIZE_OPC-1:0] OPC_HLT = 8'hFF;

   // Target fields: top bit flags a valid write, low bits select the register.
   localparam int unsigned TGT_GP_VLD = 4;
   localparam int unsigned TGT_SR_VLD = 2;

   typedef struct packed {
      logic [SIZE_ADDR-1:0]   pc;
      logic [SIZE_DATA-1:0]   instr;
      logic [SIZE_OPC-1:0]    opc;
      logic [SIZE_TGT_GP-1:0] tgt_gp;
      logic [SIZE_TGT_SR-1:0] tgt_sr;
      logic [SIZE_DATA-1:0]   result;
   } wb_instr_t;

   function automatic logic [3:0] gp_index(input logic [SIZE_TGT_GP-1:0] tgt);
      return tgt[3:0];
   endfunction

   function automatic logic [1:0] sr_index(input logic [SIZE_TGT_SR-1:0] tgt);
      return tgt[1:0];
   endfunction

endpackage

// File: rtl/stg5wb_regfile_gp.sv
// 16-entry GP register file: one write port, two async read ports, register 0
// hardwired to zero. Write-through bypass when STG5WB_BYPASS_EN is defined.
module stg5wb_regfile_gp
   import stg5wb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [3:0]           waddr,
   input  logic [SIZE_DATA-1:0] wdata,
   input  logic [3:0]           ra_addr,
   output logic [SIZE_DATA-1:0] ra_data,
   input  logic [3:0]           rb_addr,
   output logic [SIZE_DATA-1:0] rb_data
);

   logic [SIZE_DATA-1:0] mem_q [NUM_GP];
   logic                 wr_ok;

   assign wr_ok = we && (waddr != 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_GP; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      ra_data = mem_q[ra_addr];
      rb_data = mem_q[rb_addr];
`ifdef STG5WB_BYPASS_EN
      if (wr_ok && (waddr == ra_addr)) ra_data = wdata;
      if (wr_ok && (waddr == rb_addr)) rb_data = wdata;
`endif
      if (ra_addr == 4'd0) ra_data = '0;
      if (rb_addr == 4'd0) rb_data = '0;
   end

endmodule

// File: rtl/stg5wb.sv
// Write-back stage: latches the memory-access outputs, commits to the GP/SR
// files, counts retired instructions and holds a sticky halt. Macro: STG5WB_BYPASS_EN.
module stg5wb
   import stg5wb_pkg::*;
(
   input  logic                   iw_clk,
   input  logic                   iw_rst,
   input  logic [SIZE_ADDR-1:0]   iw_pc,
   input  logic [SIZE_DATA-1:0]   iw_instr,
   input  logic [SIZE_OPC-1:0]    iw_opc,
   input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
   input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
   input  logic [SIZE_DATA-1:0]   iw_result,
   input  logic [3:0]             iw_rd_a_addr,
   input  logic [3:0]             iw_rd_b_addr,
   output logic [SIZE_DATA-1:0]   ow_rd_a_data,
   output logic [SIZE_DATA-1:0]   ow_rd_b_data,
   input  logic [1:0]             iw_rd_sr_addr,
   output logic [SIZE_DATA-1:0]   ow_rd_sr_data,
   output logic [SIZE_ADDR-1:0]   ow_pc,
   output logic [SIZE_DATA-1:0]   ow_retired,
   output logic                   ow_halt
);

   wb_instr_t            wb_q;
   logic                 halt_q;
   logic [SIZE_DATA-1:0] retired_q;
   logic [SIZE_DATA-1:0] sr_q [NUM_SR];

   logic       is_hlt;
   logic       commit_ok;
   logic       gp_we;
   logic       sr_we;
   logic       retire;
   logic [3:0] gp_idx;
   logic [1:0] sr_idx;
   logic       unused_instr;

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         wb_q <= '0;
      end else begin
         wb_q <= '{pc:     iw_pc,
                   instr:  iw_instr,
                   opc:    iw_opc,
                   tgt_gp: iw_tgt_gp,
                   tgt_sr: iw_tgt_sr,
                   result: iw_result};
      end
   end

   // HLT retires but never writes; once halted nothing commits until reset.
   assign is_hlt    = (wb_q.opc == OPC_HLT);
   assign commit_ok = !halt_q && !is_hlt;
   assign gp_idx    = gp_index(wb_q.tgt_gp);
   assign sr_idx    = sr_index(wb_q.tgt_sr);
   assign gp_we     = wb_q.tgt_gp[TGT_GP_VLD] && commit_ok && (gp_idx != 4'd0);
   assign sr_we     = wb_q.tgt_sr[TGT_SR_VLD] && commit_ok;
   assign retire    = (wb_q.opc != OPC_NOP) && !halt_q;

   assign unused_instr = ^wb_q.instr;

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         halt_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         if (is_hlt) halt_q <= 1'b1;
         if (retire) retired_q <= retired_q + SIZE_DATA'(1);
      end
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         for (int i = 0; i < NUM_SR; i++) begin
            sr_q[i] <= '0;
         end
      end else if (sr_we) begin
         sr_q[sr_idx] <= wb_q.result;
      end
   end

   always_comb begin
      ow_rd_sr_data = sr_q[iw_rd_sr_addr];
`ifdef STG5WB_BYPASS_EN
      if (sr_we && (sr_idx == iw_rd_sr_addr)) ow_rd_sr_data = wb_q.result;
`endif
   end

   stg5wb_regfile_gp u_regfile_gp (
      .clk     (iw_clk),
      .rst     (iw_rst),
      .we      (gp_we),
      .waddr   (gp_idx),
      .wdata   (wb_q.result),
      .ra_addr (iw_rd_a_addr),
      .ra_data (ow_rd_a_data),
      .rb_addr (iw_rd_b_addr),
      .rb_data (ow_rd_b_data)
   );

   assign ow_pc      = wb_q.pc;
   assign ow_retired = retired_q;
   assign ow_halt    = halt_q;

endmodule

// File: tb/tb_stg5wb.sv
// Scoreboard bench for stg5wb: the driver queues expected register/counter
// values, a monitor process reads the DUT between clock edges and compares.
module tb_stg5wb;

   localparam int K_GPA = 0, K_GPB = 1, K_SR = 2, K_RET = 3, K_HALT = 4, K_PC = 5;
`ifdef STG5WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      int          kind;
      int          addr;
      logic [23:0] exp;
      int          step;
   } item_t;

   logic        iw_clk = 1'b0;
   logic        iw_rst = 1'b1;
   logic [23:0] pc = '0;
   logic [23:0] instr = '0;
   logic [7:0]  opc = '0;
   logic [4:0]  tgt_gp = '0;
   logic [2:0]  tgt_sr = '0;
   logic [23:0] result = '0;
   logic [3:0]  rd_a_addr = '0;
   logic [3:0]  rd_b_addr = '0;
   logic [1:0]  rd_sr_addr = '0;
   logic [23:0] rd_a_data, rd_b_data, rd_sr_data, pc_out, retired;
   logic        halt;

   item_t q[$];
   int    checks = 0;
   int    failures = 0;
   int    step = 0;
   bit    mon_busy = 1'b0;

   stg5wb dut (
      .iw_clk        (iw_clk),
      .iw_rst        (iw_rst),
      .iw_pc         (pc),
      .iw_instr      (instr),
      .iw_opc        (opc),
      .iw_tgt_gp     (tgt_gp),
      .iw_tgt_sr     (tgt_sr),
      .iw_result     (result),
      .iw_rd_a_addr  (rd_a_addr),
      .iw_rd_b_addr  (rd_b_addr),
      .ow_rd_a_data  (rd_a_data),
      .ow_rd_b_data  (rd_b_data),
      .iw_rd_sr_addr (rd_sr_addr),
      .ow_rd_sr_data (rd_sr_data),
      .ow_pc         (pc_out),
      .ow_retired    (retired),
      .ow_halt       (halt)
   );

   always #5 iw_clk = ~iw_clk;

   function automatic string kname(input int k);
      case (k)
         K_GPA:   return "gp_a";
         K_GPB:   return "gp_b";
         K_SR:    return "sr";
         K_RET:   return "retired";
         K_HALT:  return "halt";
         default: return "pc";
      endcase
   endfunction

   // Monitor: up to three reads per low phase, all well before the next rising edge.
   initial begin
      item_t       it;
      logic [23:0] act;
      forever begin
         @(negedge iw_clk);
         for (int n = 0; n < 3 && q.size() > 0; n++) begin
            mon_busy   = 1'b1;
            it         = q.pop_front();
            rd_a_addr  = it.addr[3:0];
            rd_b_addr  = it.addr[3:0];
            rd_sr_addr = it.addr[1:0];
            #1;
            case (it.kind)
               K_GPA:   act = rd_a_data;
               K_GPB:   act = rd_b_data;
               K_SR:    act = rd_sr_data;
               K_RET:   act = retired;
               K_HALT:  act = {23'd0, halt};
               default: act = pc_out;
            endcase
            checks++;
            if (act !== it.exp) begin
               failures++;
               $display("FAIL step%0d %s[%0d] got %h expected %h",
                        it.step, kname(it.kind), it.addr, act, it.exp);
            end
         end
         mon_busy = 1'b0;
      end
   end

   task automatic push(input int kind, input int addr, input logic [23:0] exp);
      item_t it;
      it.kind = kind;
      it.addr = addr;
      it.exp  = exp;
      it.step = step;
      q.push_back(it);
   endtask

   task automatic exp_gp(input int addr, input logic [23:0] v);
      push(K_GPA, addr, v);
      push(K_GPB, addr, v);
   endtask

   task automatic sync();
      int i;
      for (i = 0; i < 200; i++) begin
         if (q.size() == 0 && !mon_busy) break;
         @(posedge iw_clk);
      end
      if (i == 200) begin
         checks++;
         failures++;
         $display("FAIL step%0d monitor_drain got %0d pending expected 0", step, q.size());
         q.delete();
      end
   endtask

   task automatic drive(input logic [23:0] p, input logic [7:0] o, input logic [4:0] g,
                        input logic [2:0] s, input logic [23:0] r);
      @(negedge iw_clk);
      pc     = p;
      instr  = {o, 16'h1234};
      opc    = o;
      tgt_gp = g;
      tgt_sr = s;
      result = r;
   endtask

   task automatic idle();
      drive(24'h0, 8'h00, 5'h00, 3'b000, 24'h0);
   endtask

   // Drive one instruction; leaves the bench just after its latch edge.
   task automatic issue(input logic [23:0] p, input logic [7:0] o, input logic [4:0] g,
                        input logic [2:0] s, input logic [23:0] r);
      drive(p, o, g, s, r);
      @(posedge iw_clk);
      #1;
   endtask

   task automatic after_commit();
      idle();
      @(posedge iw_clk);
      #1;
   endtask

   initial begin
      // Reset state
      step = 1;
      repeat (3) @(posedge iw_clk);
      @(negedge iw_clk);
      iw_rst = 1'b0;
      for (int i = 1; i < 16; i++) exp_gp(i, 24'h0);
      for (int i = 0; i < 4; i++) push(K_SR, i, 24'h0);
      push(K_RET, 0, 24'h0);
      push(K_HALT, 0, 24'h0);
      push(K_PC, 0, 24'h0);
      sync();

      // GP3 write; intervening read depends on bypass
      step = 2;
      issue(24'h000100, 8'h01, 5'h13, 3'b000, 24'h00ABCD);
      exp_gp(3, BYP ? 24'h00ABCD : 24'h0);
      push(K_PC, 0, 24'h000100);
      after_commit();
      exp_gp(3, 24'h00ABCD);
      push(K_RET, 0, 24'h1);
      sync();

      // Write to GP0 is dropped, even through bypass
      step = 3;
      issue(24'h000104, 8'h01, 5'h10, 3'b000, 24'hFFFFFF);
      exp_gp(0, 24'h0);
      after_commit();
      exp_gp(0, 24'h0);
      push(K_RET, 0, 24'h2);
      sync();

      // GP2 and SR1 in the same cycle
      step = 4;
      issue(24'h000108, 8'h02, 5'h12, 3'b101, 24'h000042);
      push(K_SR, 1, BYP ? 24'h000042 : 24'h0);
      after_commit();
      exp_gp(2, 24'h000042);
      push(K_SR, 1, 24'h000042);
      push(K_RET, 0, 24'h3);
      sync();

      // Back-to-back writes to GP5: later value persists
      step = 5;
      drive(24'h00010C, 8'h01, 5'h15, 3'b000, 24'h000111);
      drive(24'h000110, 8'h01, 5'h15, 3'b000, 24'h000222);
      after_commit();
      exp_gp(5, 24'h000222);
      push(K_RET, 0, 24'h5);
      sync();

      // SR-only write
      step = 6;
      issue(24'h000114, 8'h03, 5'h00, 3'b111, 24'h5A5A5A);
      after_commit();
      push(K_SR, 3, 24'h5A5A5A);
      push(K_RET, 0, 24'h6);
      sync();

      // NOP with a valid target still commits but does not retire
      step = 7;
      issue(24'h000118, 8'h00, 5'h16, 3'b000, 24'h000077);
      after_commit();
      exp_gp(6, 24'h000077);
      push(K_RET, 0, 24'h6);
      sync();

      // HLT retires, writes nothing, sets halt
      step = 8;
      issue(24'h00011C, 8'hFF, 5'h14, 3'b100, 24'h000009);
      after_commit();
      exp_gp(4, 24'h0);
      push(K_SR, 0, 24'h0);
      push(K_HALT, 0, 24'h1);
      push(K_RET, 0, 24'h7);
      sync();

      // After halt: no commit, no bypass, no retire
      step = 9;
      issue(24'h000120, 8'h01, 5'h14, 3'b100, 24'h000007);
      exp_gp(4, 24'h0);
      after_commit();
      exp_gp(4, 24'h0);
      push(K_SR, 0, 24'h0);
      push(K_RET, 0, 24'h7);
      push(K_HALT, 0, 24'h1);
      sync();

      // Async reset while a write is pending: reset wins
      step = 10;
      issue(24'h000124, 8'h01, 5'h18, 3'b000, 24'h000123);
      #1;
      iw_rst = 1'b1;
      pc = '0; instr = '0; opc = '0; tgt_gp = '0; tgt_sr = '0; result = '0;
      push(K_HALT, 0, 24'h0);
      push(K_RET, 0, 24'h0);
      push(K_PC, 0, 24'h0);
      sync();
      @(negedge iw_clk);
      iw_rst = 1'b0;
      @(posedge iw_clk);
      #1;
      exp_gp(8, 24'h0);
      exp_gp(3, 24'h0);
      push(K_SR, 1, 24'h0);
      push(K_HALT, 0, 24'h0);
      sync();

      // Counter wrap
      step = 11;
      @(negedge iw_clk);
      force dut.retired_q = 24'hFFFFFF;
      @(negedge iw_clk);
      release dut.retired_q;
      @(posedge iw_clk);
      #1;
      push(K_RET, 0, 24'hFFFFFF);
      sync();
      issue(24'h000128, 8'h05, 5'h00, 3'b000, 24'h0);
      after_commit();
      push(K_RET, 0, 24'h0);
      sync();
      repeat (3) idle();
      @(posedge iw_clk);
      #1;
      push(K_RET, 0, 24'h0);
      sync();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
